// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_pkg
// Description : Shared types and constants for the counter mode controller:
//               FSM state encoding and counter direction values.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    // Encodings are visible on the state LEDs, so they are fixed explicitly
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rise_edge.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge
// Description : 1-bit rising-edge detector. History resets to 1 so a level
//               already high when reset releases never produces an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic hist_q;
    logic hist_d;

    // Next history is simply the current level
    always_comb begin
        hist_d = din;
    end

    // History register, forced high in reset to suppress a held-button edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise = din & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl
// Description : Mode controller for the up/down loadable display counter.
//               Turns debounced run/dir/load buttons and the divider tick
//               into registered enable, direction and load strobes, with
//               run/pause, reload and limit handling.
//               Build option COUNTER_CTRL_BOUNCE_EN: when defined the count
//               bounces off 0 and MAX_VAL; when undefined it wraps modulo
//               MAX_VAL+1 using a load strobe at the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_run,
    input  logic             btn_dir,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             up_down,
    output logic             load,
    output logic [WIDTH-1:0] load_val,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             run_edge;
    logic             dir_edge;
    logic             load_edge;

    state_t           state_q,    state_d;
    logic             dir_q,      dir_d;
    logic             cnt_en_q,   cnt_en_d;
    logic             load_q,     load_d;
    logic             up_down_q,  up_down_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;

    logic             at_limit;
    logic             dir_eff;

    rise_edge u_edge_run (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_run),
        .rise (run_edge)
    );

    rise_edge u_edge_dir (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_dir),
        .rise (dir_edge)
    );

    rise_edge u_edge_load (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_load),
        .rise (load_edge)
    );

    // Limit detection and the direction the next step will actually take
    always_comb begin
        at_limit = ((dir_q == DIR_UP)   && (count == MAX_W)) ||
                   ((dir_q == DIR_DOWN) && (count == '0));
`ifdef COUNTER_CTRL_BOUNCE_EN
        dir_eff  = at_limit ? ~dir_q : dir_q;
`else
        dir_eff  = dir_q;
`endif
    end

    // Next-state and output strobe logic; strobes default low for one-cycle pulses
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_en_d   = 1'b0;
        load_d     = 1'b0;
        up_down_d  = up_down_q;
        load_val_d = load_val_q;

        // Direction presses are dropped only during the single load cycle
        if (state_q != S_LOAD) begin
            dir_d = dir_q ^ dir_edge;
        end

        case (state_q)
            S_IDLE, S_PAUSE: begin
                // Load has priority; a simultaneous run press is discarded
                if (load_edge) begin
                    state_d    = S_LOAD;
                    load_d     = 1'b1;
                    load_val_d = (data_in > MAX_W) ? MAX_W : data_in;
                end else if (run_edge) begin
                    state_d = S_RUN;
                end
            end

            S_LOAD: begin
                state_d = S_IDLE;
            end

            S_RUN: begin
                if (run_edge) begin
                    state_d = S_PAUSE;
                end
                if (tick) begin
                    up_down_d = dir_eff;
`ifdef COUNTER_CTRL_BOUNCE_EN
                    // Reversal at a limit and a same-cycle press combine by XOR
                    cnt_en_d  = 1'b1;
                    dir_d     = dir_eff ^ dir_edge;
`else
                    // Wrap is done with a load so the counter never leaves range
                    if (at_limit) begin
                        load_d     = 1'b1;
                        load_val_d = (dir_q == DIR_UP) ? '0 : MAX_W;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dir_q      <= DIR_UP;
            cnt_en_q   <= 1'b0;
            load_q     <= 1'b0;
            up_down_q  <= DIR_UP;
            load_val_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_en_q   <= cnt_en_d;
            load_q     <= load_d;
            up_down_q  <= up_down_d;
            load_val_q <= load_val_d;
        end
    end

    assign cnt_en   = cnt_en_q;
    assign up_down  = up_down_q;
    assign load     = load_q;
    assign load_val = load_val_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Self-checking bench for counter_ctrl. Models the downstream
//               counter, keeps a behavioural reference of the controller and
//               compares every cycle, plus directed literal scenarios.
//               Honours COUNTER_CTRL_BOUNCE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             btn_run;
    logic             btn_dir;
    logic             btn_load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    counter_ctrl #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_load (btn_load),
        .data_in  (data_in),
        .count    (count),
        .cnt_en   (cnt_en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Downstream counter driven by the controller
    always @(posedge clk) begin
        if (rst)         count <= '0;
        else if (load)   count <= load_val;
        else if (cnt_en) count <= up_down ? count + 1'b1 : count - 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // States as numbers: 0 idle, 1 load, 2 run, 3 pause
    int m_state;
    bit m_dir;
    bit e_ce, e_ld, e_ud;
    int e_lv;
    bit h_run, h_dir, h_load;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit r_e, d_e, l_e, was_load;
        int nxt;
        r_e = btn_run  && !h_run;
        d_e = btn_dir  && !h_dir;
        l_e = btn_load && !h_load;
        h_run = btn_run; h_dir = btn_dir; h_load = btn_load;
        if (rst) begin
            m_state = 0; m_dir = 1'b1;
            e_ce = 1'b0; e_ld = 1'b0; e_ud = 1'b1; e_lv = 0;
            h_run = 1'b1; h_dir = 1'b1; h_load = 1'b1;
            m_valid = 1'b1;
        end else begin
            was_load = (m_state == 1);
            e_ce = 1'b0;
            e_ld = 1'b0;
            if (m_state == 0 || m_state == 3) begin
                if (l_e) begin
                    m_state = 1;
                    e_ld    = 1'b1;
                    e_lv    = (int'(data_in) > MAX_VAL) ? MAX_VAL : int'(data_in);
                end else if (r_e) begin
                    m_state = 2;
                end
            end else if (m_state == 1) begin
                m_state = 0;
            end else begin
                if (tick) begin
                    nxt = int'(count) + (m_dir ? 1 : -1);
                    if (nxt >= 0 && nxt <= MAX_VAL) begin
                        e_ce = 1'b1;
                        e_ud = m_dir;
                    end else begin
`ifdef COUNTER_CTRL_BOUNCE_EN
                        m_dir = !m_dir;
                        e_ce  = 1'b1;
                        e_ud  = m_dir;
`else
                        e_ld  = 1'b1;
                        e_lv  = (nxt + MAX_VAL + 1) % (MAX_VAL + 1);
                        e_ud  = m_dir;
`endif
                    end
                end
                if (r_e) m_state = 3;
            end
            if (!was_load && d_e) m_dir = !m_dir;
        end
        #1;
        if (m_valid) begin
            check("cnt_en",   cnt_en,   e_ce);
            check("load",     load,     e_ld);
            check("up_down",  up_down,  e_ud);
            check("load_val", load_val, e_lv);
            check("state",    state,    m_state);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic drive(input bit r, input bit d, input bit l, input bit t);
        @(negedge clk);
        btn_run = r; btn_dir = d; btn_load = l; tick = t;
        settle();
    endtask

    task automatic rel();
        @(negedge clk);
        btn_run = 0; btn_dir = 0; btn_load = 0; tick = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; tick = 0; btn_run = 0; btn_dir = 0; btn_load = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // One tick, spaced so the next call is at least 3 cycles later
    task automatic tick_once(input bit with_dir, output logic ce, output logic ld,
                             output logic ud, output logic [WIDTH-1:0] lv,
                             output logic [WIDTH-1:0] cnt);
        drive(0, with_dir, 0, 1);
        ce = cnt_en; ld = load; ud = up_down; lv = load_val;
        rel();
        settle();
        cnt = count;
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef COUNTER_CTRL_BOUNCE_EN
    int exp_seq [12] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
`else
    int exp_seq [12] = '{8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif

    initial begin
        logic ce, ld, ud;
        logic [WIDTH-1:0] lv, cnt;
        int since;

        rst = 1; tick = 0; btn_run = 1; btn_dir = 0; btn_load = 0; data_in = '0;

        // Run held through reset must not start the counter
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(posedge clk);
        #2;
        check("held_run_state", state, 2'b00);
        check("held_run_ud", up_down, 1'b1);
        @(negedge clk); btn_run = 0;
        drive(1, 0, 0, 0);
        check("repress_run_state", state, 2'b10);
        rel();

        // Load with clamping from idle
        do_reset();
        data_in = 4'd13;
        drive(0, 0, 1, 0);
        check("load_strobe", load, 1'b1);
        check("load_clamp", load_val, 4'd9);
        check("load_state", state, 2'b01);
        check("model_lv_pin", e_lv, 9);
        rel();
        settle();
        check("load_done_state", state, 2'b00);
        check("load_done_strobe", load, 1'b0);
        check("load_count", count, 4'd9);

        // Twelve ticks from 7
        do_reset();
        data_in = 4'd7;
        drive(0, 0, 1, 0);
        rel();
        settle();
        check("start7_count", count, 4'd7);
        drive(1, 0, 0, 0);
        check("run_state", state, 2'b10);
        rel();
        for (int i = 0; i < 12; i++) begin
            tick_once(1'b0, ce, ld, ud, lv, cnt);
            check("seq_count", cnt, exp_seq[i]);
            if (i == 2) begin
`ifdef COUNTER_CTRL_BOUNCE_EN
                check("limit_ce", ce, 1'b1);
                check("limit_ud", ud, 1'b0);
`else
                check("limit_ld", ld, 1'b1);
                check("limit_lv", lv, 4'd0);
                check("limit_ce", ce, 1'b0);
`endif
            end
        end

        // Dir press together with the tick at the upper limit
        do_reset();
        data_in = 4'd9;
        drive(0, 0, 1, 0);
        rel();
        drive(1, 0, 0, 0);
        rel();
        tick_once(1'b1, ce, ld, ud, lv, cnt);
`ifdef COUNTER_CTRL_BOUNCE_EN
        check("dirlim_count1", cnt, 4'd8);
        check("dirlim_model_dir", m_dir, 1'b1);
        tick_once(1'b0, ce, ld, ud, lv, cnt);
        check("dirlim_count2", cnt, 4'd9);
`else
        check("dirlim_count1", cnt, 4'd0);
        check("dirlim_model_dir", m_dir, 1'b0);
        tick_once(1'b0, ce, ld, ud, lv, cnt);
        check("dirlim_count2", cnt, 4'd9);
`endif

        // Run and load together in pause
        do_reset();
        drive(1, 0, 0, 0);
        rel();
        drive(1, 0, 0, 0);
        check("pause_state", state, 2'b11);
        rel();
        data_in = 4'd5;
        drive(1, 0, 1, 0);
        check("pause_both_state", state, 2'b01);
        check("pause_both_load", load, 1'b1);
        check("pause_both_lv", load_val, 4'd5);
        rel();
        settle();
        check("pause_both_idle", state, 2'b00);

        // Mid-run reset with a pending tick
        drive(1, 0, 0, 0);
        rel();
        drive(0, 1, 0, 0);
        rel();
        tick_once(1'b0, ce, ld, ud, lv, cnt);
        check("down_ud", ud, 1'b0);
        check("down_count", cnt, 4'd4);
        @(negedge clk);
        rst = 1; tick = 1;
        settle();
        check("rst_cnt_en", cnt_en, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_up_down", up_down, 1'b1);
        check("rst_load_val", load_val, 4'd0);
        check("rst_state", state, 2'b00);
        @(negedge clk);
        rst = 0; tick = 0;

        // Randomized traffic checked by the reference every cycle
        do_reset();
        since = 3;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (since >= 3 && $urandom_range(0, 2) == 0) begin
                tick = 1; since = 1;
            end else begin
                tick = 0; since++;
            end
            if ($urandom_range(0, 7) == 0) btn_run  = ~btn_run;
            if ($urandom_range(0, 9) == 0) btn_dir  = ~btn_dir;
            if ($urandom_range(0, 15) == 0) btn_load = ~btn_load;
            data_in = WIDTH'($urandom_range(0, 15));
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 0; tick = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
